// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data ports.
// Combinational grant with a DM-streak fairness cap; responses return one cycle after grant.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_req,
  input  logic [31:0] im_addr,
  output logic        im_gnt,
  output logic        im_valid,
  output logic [31:0] im_rdata,
  input  logic        dm_req,
  input  logic        dm_read,
  input  logic [3:0]  dm_web,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        sram_cs,
  output logic        sram_oe,
  output logic [3:0]  sram_web,
  output logic [13:0] sram_a,
  output logic [31:0] sram_di,
  input  logic [31:0] sram_do
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RSP_IM    = 2'd1;
  localparam logic [1:0] RSP_DM_RD = 2'd2;
  localparam logic [1:0] RSP_DM_WR = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [1:0]  dm_streak;
  logic        force_im;
  logic        dm_store;
  logic [31:0] im_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{im_addr[31:16], im_addr[1:0], dm_addr[31:16], dm_addr[1:0]};

  assign force_im = im_req && (dm_streak == 2'd3);
  assign im_gnt   = rst && im_req && (!dm_req || force_im);
  assign dm_gnt   = rst && dm_req && !force_im;
  assign dm_store = dm_gnt && !dm_read;

  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = 4'hf;
    sram_a   = '0;
    sram_di  = '0;
    if (im_gnt) begin
      sram_cs = 1'b1;
      sram_oe = 1'b1;
      sram_a  = im_addr[15:2];
    end else if (dm_gnt) begin
      sram_cs = 1'b1;
      sram_a  = dm_addr[15:2];
      if (dm_read) begin
        sram_oe = 1'b1;
      end else begin
        sram_web = dm_web;
        sram_di  = dm_wdata;
      end
    end
  end

  always_comb begin
    state_next = IDLE;
    if (im_gnt)        state_next = RSP_IM;
    else if (dm_store) state_next = RSP_DM_WR;
    else if (dm_gnt)   state_next = RSP_DM_RD;
  end

  assign im_valid = rst && (state == RSP_IM);
  assign dm_valid = rst && ((state == RSP_DM_RD) || (state == RSP_DM_WR));

  // Read data bypasses straight from the SRAM during the response cycle so it
  // lines up with the valid pulse; the registered copy holds it afterwards.
  assign im_rdata = im_valid ? sram_do : im_rdata_q;
  assign dm_rdata = (rst && (state == RSP_DM_RD)) ? sram_do : dm_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      dm_streak  <= '0;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_next;
      if (!im_req || im_gnt)
        dm_streak <= '0;
      else if (dm_gnt)
        dm_streak <= dm_streak + 2'd1;
      if (state == RSP_IM)
        im_rdata_q <= sram_do;
      if (state == RSP_DM_RD)
        dm_rdata_q <= sram_do;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_valid;
  logic [31:0] im_rdata;
  logic        dm_req;
  logic        dm_read;
  logic [3:0]  dm_web;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        sram_cs;
  logic        sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  int unsigned n_cmp;
  int unsigned n_err;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_valid(im_valid), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_read(dm_read), .dm_web(dm_web), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fair_dm;
  logic [3:0] fair2_dm;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    im_req   = 1'b0;
    im_addr  = '0;
    dm_req   = 1'b0;
    dm_read  = 1'b1;
    dm_web   = 4'hf;
    dm_addr  = '0;
    dm_wdata = '0;
    sram_do  = '0;
    fair_dm  = 6'b110111;  // bit i = DM grant expected in cycle i
    fair2_dm = 4'b0111;

    tick();
    tick();
    // Reset: requests asserted must be ignored
    im_req = 1'b1; dm_req = 1'b1;
    #1;
    chk("rst_im_gnt", {31'd0, im_gnt}, 32'd0);
    chk("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
    chk("rst_valid", {30'd0, im_valid, dm_valid}, 32'd0);
    chk("rst_cs", {31'd0, sram_cs}, 32'd0);
    chk("rst_web", {28'd0, sram_web}, 32'hf);
    chk("rst_a", {18'd0, sram_a}, 32'd0);
    chk("rst_im_rdata", im_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    im_req = 1'b0; dm_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Fetch
    im_req = 1'b1; im_addr = 32'h0000_0104;
    #1;
    chk("fetch_gnt", {31'd0, im_gnt}, 32'd1);
    chk("fetch_dm_gnt", {31'd0, dm_gnt}, 32'd0);
    chk("fetch_a", {18'd0, sram_a}, 32'h041);
    chk("fetch_oe_cs", {30'd0, sram_oe, sram_cs}, 32'd3);
    chk("fetch_web", {28'd0, sram_web}, 32'hf);
    tick();
    im_req = 1'b0; sram_do = 32'h0000_0013;
    #1;
    chk("fetch_valid", {31'd0, im_valid}, 32'd1);
    chk("fetch_rdata", im_rdata, 32'h0000_0013);
    chk("fetch_idle_cs", {31'd0, sram_cs}, 32'd0);
    tick();
    sram_do = 32'hDEAD_BEEF;
    #1;
    chk("fetch_valid_off", {31'd0, im_valid}, 32'd0);
    chk("fetch_rdata_hold", im_rdata, 32'h0000_0013);

    // Simultaneous requests: DM load wins
    im_req = 1'b1; im_addr = 32'h0000_0200;
    dm_req = 1'b1; dm_read = 1'b1; dm_addr = 32'h0000_8008;
    #1;
    chk("sim_dm_gnt", {31'd0, dm_gnt}, 32'd1);
    chk("sim_im_gnt", {31'd0, im_gnt}, 32'd0);
    chk("sim_a", {18'd0, sram_a}, 32'h2002);
    chk("sim_oe", {31'd0, sram_oe}, 32'd1);
    tick();
    dm_req = 1'b0; sram_do = 32'h5566_7788;
    #1;
    chk("sim_dm_valid", {31'd0, dm_valid}, 32'd1);
    chk("sim_dm_rdata", dm_rdata, 32'h5566_7788);
    chk("sim_im_gnt2", {31'd0, im_gnt}, 32'd1);
    chk("sim_a2", {18'd0, sram_a}, 32'h080);
    tick();
    im_req = 1'b0; sram_do = 32'h0000_0011;
    // Store issued in the same cycle as the IM response
    dm_req = 1'b1; dm_read = 1'b0; dm_web = 4'he; dm_wdata = 32'hAABB_CCDD; dm_addr = 32'h0000_0010;
    #1;
    chk("sim_im_valid", {31'd0, im_valid}, 32'd1);
    chk("sim_im_rdata", im_rdata, 32'h0000_0011);
    chk("sim_dm_valid_off", {31'd0, dm_valid}, 32'd0);
    chk("sim_dm_rdata_hold", dm_rdata, 32'h5566_7788);
    chk("st_gnt", {31'd0, dm_gnt}, 32'd1);
    chk("st_web", {28'd0, sram_web}, 32'he);
    chk("st_di", sram_di, 32'hAABB_CCDD);
    chk("st_oe", {31'd0, sram_oe}, 32'd0);
    chk("st_a", {18'd0, sram_a}, 32'h004);
    tick();
    // Store with all bytes disabled, back-to-back with the first store's ack
    dm_web = 4'hf; sram_do = 32'h9999_9999;
    #1;
    chk("st_valid", {31'd0, dm_valid}, 32'd1);
    chk("st_rdata_hold", dm_rdata, 32'h5566_7788);
    chk("stf_gnt", {31'd0, dm_gnt}, 32'd1);
    chk("stf_cs", {31'd0, sram_cs}, 32'd1);
    chk("stf_web", {28'd0, sram_web}, 32'hf);
    tick();
    dm_req = 1'b0;
    #1;
    chk("stf_valid", {31'd0, dm_valid}, 32'd1);
    chk("stf_rdata_hold", dm_rdata, 32'h5566_7788);
    chk("stf_idle_di", sram_di, 32'd0);
    tick();

    // Fairness: both held continuously
    im_req = 1'b1; dm_req = 1'b1; dm_read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("fair_dm_%0d", i), {31'd0, dm_gnt}, {31'd0, fair_dm[i]});
      chk($sformatf("fair_im_%0d", i), {31'd0, im_gnt}, {31'd0, ~fair_dm[i]});
      tick();
    end
    // im_req low for one cycle clears the streak
    im_req = 1'b0;
    #1;
    chk("fair_clr_dm", {31'd0, dm_gnt}, 32'd1);
    tick();
    im_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fair2_dm_%0d", i), {31'd0, dm_gnt}, {31'd0, fair2_dm[i]});
      tick();
    end
    im_req = 1'b0; dm_req = 1'b0;
    tick();

    // Back-to-back fetches
    im_req = 1'b1; im_addr = 32'h0000_0400;
    #1;
    chk("b2b_gnt0", {31'd0, im_gnt}, 32'd1);
    chk("b2b_a0", {18'd0, sram_a}, 32'h100);
    tick();
    im_addr = 32'h0000_0404; sram_do = 32'h0000_00A1;
    #1;
    chk("b2b_valid0", {31'd0, im_valid}, 32'd1);
    chk("b2b_rdata0", im_rdata, 32'h0000_00A1);
    chk("b2b_gnt1", {31'd0, im_gnt}, 32'd1);
    chk("b2b_a1", {18'd0, sram_a}, 32'h101);
    tick();
    im_req = 1'b0; sram_do = 32'h0000_00A2;
    #1;
    chk("b2b_valid1", {31'd0, im_valid}, 32'd1);
    chk("b2b_rdata1", im_rdata, 32'h0000_00A2);
    tick();
    #1;
    chk("b2b_valid_off", {31'd0, im_valid}, 32'd0);
    chk("b2b_rdata_hold", im_rdata, 32'h0000_00A2);

    // Reset in the cycle after a grant drops the pending response
    im_req = 1'b1; im_addr = 32'h0000_0008;
    #1;
    chk("rr_gnt", {31'd0, im_gnt}, 32'd1);
    tick();
    rst = 1'b0; im_req = 1'b0; sram_do = 32'h0000_0077;
    #1;
    chk("rr_valid_in_rst", {30'd0, im_valid, dm_valid}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rr_valid_after", {30'd0, im_valid, dm_valid}, 32'd0);
    chk("rr_im_rdata", im_rdata, 32'd0);
    chk("rr_dm_rdata", dm_rdata, 32'd0);
    chk("rr_cs", {31'd0, sram_cs}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have the ports below; clock and reset are listed first.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- im_req  in  1  instruction-fetch read request; held high until im_gnt.
- im_addr  in  32  fetch byte address; stable while im_req is high.
- im_gnt  out  1  fetch request issued to the SRAM this cycle.
- im_valid  out  1  one-cycle pulse when im_rdata is valid.
- im_rdata  out  32  fetch data; holds the last value between pulses.
- dm_req  in  1  data request; held high until dm_gnt.
- dm_read  in  1  1 = load, 0 = store.
- dm_web  in  4  store byte write-enable, active-low (4'hf = no byte written, 4'h0 = word).
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  data request issued this cycle.
- dm_valid  out  1  one-cycle pulse marking load data or store completion.
- dm_rdata  out  32  load data; holds the last value between pulses.
- sram_cs  out  1  SRAM chip select.
- sram_oe  out  1  SRAM output enable.
- sram_web  out  4  SRAM byte write-enable, active-low.
- sram_a  out  14  SRAM word address.
- sram_di  out  32  SRAM write data.
- sram_do  in  32  SRAM read data; valid one cycle after the address is presented.

Function
REQ-002 Arbitration SHALL be combinational in the current cycle; the granted requester's address and controls SHALL drive the SRAM in its grant cycle.
REQ-003 At most one of im_gnt and dm_gnt SHALL be high in any cycle.
REQ-004 Priority: dm_req SHALL win over im_req, except when the fairness rule (REQ-005) forces an IM grant.
REQ-005 Fairness: a 2-bit counter dm_streak SHALL count DM grants made while im_req is high.
- When dm_streak == 3 and im_req is high, the next grant SHALL go to IM.
- dm_streak SHALL clear on any IM grant, and in any cycle in which im_req is low.
REQ-006 A new grant SHALL be allowed in every cycle, including the cycle in which the previous response is returned (fully pipelined, one access per cycle).
REQ-007 SRAM drive on a grant:
- sram_cs = 1.
- sram_a = addr[15:2].
- IM grant, or DM grant with dm_read = 1: sram_oe = 1, sram_web = 4'hf.
- DM grant with dm_read = 0: sram_oe = 0, sram_web = dm_web, sram_di = dm_wdata.
REQ-008 With no grant, the SRAM outputs SHALL idle at sram_cs = 0, sram_oe = 0, sram_web = 4'hf, sram_a = 0, sram_di = 0.
REQ-009 Response FSM states:
- IDLE: no response pending.
- RSP_IM: IM response due this cycle.
- RSP_DM_RD: DM load response due this cycle.
- RSP_DM_WR: DM store response due this cycle.
REQ-010 FSM transitions: the next state SHALL be selected by this cycle's grant (IM grant -> RSP_IM, DM load -> RSP_DM_RD, DM store -> RSP_DM_WR, no grant -> IDLE), from any state.
REQ-011 In RSP_IM the block SHALL pulse im_valid and register sram_do into im_rdata.
REQ-012 In RSP_DM_RD the block SHALL pulse dm_valid and register sram_do into dm_rdata.
REQ-013 In RSP_DM_WR the block SHALL pulse dm_valid and leave dm_rdata unchanged.
REQ-014 Latency from grant to valid SHALL be exactly 1 cycle.
REQ-015 A store with dm_web = 4'hf SHALL still be granted and acknowledged; no SRAM byte is written.
REQ-016 Address bits [1:0] and [31:16] SHALL be ignored.

Reset
REQ-017 While rst = 0 at a clock edge, the block SHALL set state = IDLE, dm_streak = 0, im_rdata = 0 and dm_rdata = 0.
REQ-018 While rst = 0, all gnt and valid outputs SHALL be 0 and the SRAM outputs SHALL hold their idle values, regardless of requests.
REQ-019 A response pending at reset assertion SHALL be dropped: no valid pulse SHALL occur in the first cycle after rst is released.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Fetch: im_req, im_addr = 0x0000_0104, sram_do = 0x0000_0013 -> im_gnt, sram_a = 0x041, sram_oe = 1; next cycle im_valid = 1, im_rdata = 0x0000_0013.
- Simultaneous requests: im_req and dm_req (load, dm_addr = 0x0000_8008) in the same cycle -> dm_gnt, sram_a = 0x2002; IM is granted the following cycle once dm_req drops.
- Store byte: dm_read = 0, dm_web = 4'he, dm_wdata = 0xAABBCCDD -> sram_web = 4'he, sram_di = 0xAABBCCDD; dm_valid 1 cycle later; dm_rdata unchanged.
- Fairness: dm_req and im_req held continuously -> grant pattern DM, DM, DM, IM, DM, ...
- Back-to-back: fetches granted on cycles n and n+1 -> im_valid high on cycles n+1 and n+2, each carrying its own sram_do.
- Reset: rst = 0 in the cycle after a grant -> no valid pulse; after release, im_rdata = dm_rdata = 0 and state = IDLE.
